// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table checker family.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int DEFAULT_SETTLE_CYC = 2;

  function automatic int n_vec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; counting stops at zero.
module tt_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus + response checker for an N_IN-input, single-output function.
// Define TT_CHECK_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int                  N_IN       = 3,
  parameter logic [2**N_IN-1:0]  EXPECTED   = 8'hE8,
  parameter int                  SETTLE_CYC = DEFAULT_SETTLE_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [2**N_IN-1:0]   err_mask
);

  localparam int NV = n_vec(N_IN);
  localparam int CW = N_IN + 1;
  localparam int TW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  // The timer reaches zero after SETTLE_CYC cycles spent in SETTLE.
  localparam logic [TW-1:0] TMR_RELOAD = TW'(SETTLE_CYC - 1);

  tt_state_e         state_q, state_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     err_cnt_q, err_cnt_d;
  logic [NV-1:0]     err_mask_q, err_mask_d;

  logic tmr_load, tmr_dec, tmr_zero;
  logic mismatch, last_vec, stop_sweep;

  tt_settle_timer #(
    .W (TW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign mismatch = (dut_out != EXPECTED[dut_in_q]);
  assign last_vec = (dut_in_q == '1);

`ifdef TT_CHECK_STOP_ON_FAIL_EN
  assign stop_sweep = last_vec || mismatch;
`else
  assign stop_sweep = last_vec;
`endif

  always_comb begin
    state_d    = state_q;
    dut_in_d   = dut_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          dut_in_d   = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          err_mask_d = '0;
          tmr_load   = 1'b1;
        end
      end

      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_cnt_d            = err_cnt_q + CW'(1);
          err_mask_d[dut_in_q] = 1'b1;
        end
        // pass is decided here so it is already valid while done is high.
        if (stop_sweep) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = SETTLE;
          dut_in_d = dut_in_q + N_IN'(1);
          tmr_load = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a selectable model DUT on dut_out.
module tb_truth_table_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] err_mask;

  int mode;
  int n_applied;
  int n_fail;

  truth_table_checker #(
    .N_IN       (3),
    .EXPECTED   (8'hE8),
    .SETTLE_CYC (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .err_mask (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model DUTs: 0 majority, 1 stuck-at-0, 2 inverted majority, 3 majority wrong on vector 3.
  logic maj;
  always_comb begin
    maj     = (dut_in[2] & dut_in[1]) | (dut_in[2] & dut_in[0]) | (dut_in[1] & dut_in[0]);
    dut_out = maj;
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = ~maj;
      3:       dut_out = maj ^ (dut_in == 3'd3);
      default: dut_out = maj;
    endcase
  end

  typedef struct {
    int         mode;
    int         done_edge;
    bit         pass;
    int         cnt;
    logic [7:0] mask;
    int         last;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start so edge 0 samples it, then follow the sweep edge by edge.
  task automatic run_sweep(input vec_t v, input bit repulse);
    int done_edge;
    int ndone;
    int exp_vec;
    mode = v.mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_edge = -1;
    ndone = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("dut_in_after_start", 32'(dut_in), 32'd0);
    for (int e = 1; e <= v.done_edge + 2; e++) begin
      @(posedge clk);
      #1;
      if (repulse) start = (e == 4) || (e == 9);
      if (done) begin
        ndone++;
        if (done_edge < 0) done_edge = e;
      end
      exp_vec = (e / 3 < v.last) ? e / 3 : v.last;
      if (e < v.done_edge) begin
        check($sformatf("m%0d_dut_in_e%0d", v.mode, e), 32'(dut_in), 32'(exp_vec));
        check($sformatf("m%0d_busy_e%0d", v.mode, e), 32'(busy), 32'd1);
      end else if (e == v.done_edge) begin
        check($sformatf("m%0d_pass", v.mode), 32'(pass), 32'(v.pass));
        check($sformatf("m%0d_err_cnt", v.mode), 32'(err_cnt), 32'(v.cnt));
        check($sformatf("m%0d_err_mask", v.mode), 32'(err_mask), 32'(v.mask));
        check($sformatf("m%0d_busy_done", v.mode), 32'(busy), 32'd1);
      end else begin
        check($sformatf("m%0d_busy_idle_e%0d", v.mode, e), 32'(busy), 32'd0);
        check($sformatf("m%0d_dut_in_hold_e%0d", v.mode, e), 32'(dut_in), 32'(v.last));
        check($sformatf("m%0d_pass_hold_e%0d", v.mode, e), 32'(pass), 32'(v.pass));
        check($sformatf("m%0d_mask_hold_e%0d", v.mode, e), 32'(err_mask), 32'(v.mask));
      end
    end
    start = 1'b0;
    check($sformatf("m%0d_done_edge", v.mode), 32'(done_edge), 32'(v.done_edge));
    check($sformatf("m%0d_done_pulses", v.mode), 32'(ndone), 32'd1);
  endtask

  initial begin
    int seen_done;
    int d_edge;
    n_applied = 0;
    n_fail    = 0;
    mode      = 0;
    start     = 1'b0;
    rst_n     = 1'b0;

`ifdef TT_CHECK_STOP_ON_FAIL_EN
    tbl[0] = '{mode: 0, done_edge: 24, pass: 1'b1, cnt: 0, mask: 8'h00, last: 7};
    tbl[1] = '{mode: 1, done_edge: 12, pass: 1'b0, cnt: 1, mask: 8'h08, last: 3};
    tbl[2] = '{mode: 2, done_edge: 3,  pass: 1'b0, cnt: 1, mask: 8'h01, last: 0};
    tbl[3] = '{mode: 3, done_edge: 12, pass: 1'b0, cnt: 1, mask: 8'h08, last: 3};
`else
    tbl[0] = '{mode: 0, done_edge: 24, pass: 1'b1, cnt: 0, mask: 8'h00, last: 7};
    tbl[1] = '{mode: 1, done_edge: 24, pass: 1'b0, cnt: 4, mask: 8'hE8, last: 7};
    tbl[2] = '{mode: 2, done_edge: 24, pass: 1'b0, cnt: 8, mask: 8'hFF, last: 7};
    tbl[3] = '{mode: 3, done_edge: 24, pass: 1'b0, cnt: 1, mask: 8'h08, last: 7};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_in", 32'(dut_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_sweep(tbl[i], 1'b0);
      $display("sweep mode=%0d pass=%0b err_cnt=%0d err_mask=%02h", tbl[i].mode, pass, err_cnt, err_mask);
    end

    // Re-pulses of start at edges 5 and 10 must not restart or queue a sweep.
    run_sweep(tbl[0], 1'b1);
    $display("repulse sweep pass=%0b err_cnt=%0d", pass, err_cnt);
    // The next accepted start clears stale results.
    run_sweep(tbl[2], 1'b0);
    $display("rerun sweep pass=%0b err_cnt=%0d", pass, err_cnt);

    // Asynchronous reset mid-sweep.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dut_in", 32'(dut_in), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_err_mask", 32'(err_mask), 32'd0);
    seen_done = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    $display("abort sequence done_pulses=%0d", seen_done);
    run_sweep(tbl[0], 1'b0);
    $display("post-abort sweep pass=%0b err_cnt=%0d", pass, err_cnt);

    // start held high: ignored in the DONE cycle, accepted in the following IDLE cycle.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    d_edge = -1;
    for (int e = 1; e <= 40 && d_edge < 0; e++) begin
      @(posedge clk);
      #1;
      if (done) d_edge = e;
    end
    check("held_done_edge", 32'(d_edge), 32'd24);
    @(posedge clk);
    #1;
    check("held_busy_after_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("held_busy_reaccept", 32'(busy), 32'd1);
    check("held_err_cnt_cleared", 32'(err_cnt), 32'd0);
    start = 1'b0;
    d_edge = -1;
    for (int e = 1; e <= 40 && d_edge < 0; e++) begin
      @(posedge clk);
      #1;
      if (done) d_edge = e;
    end
    check("held_second_done_edge", 32'(d_edge), 32'd24);
    $display("held-start sequence second_done_edge=%0d", d_edge);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
